// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage RV32M multiply/divide unit:
// funct3 opcodes, forwarding-select codes and controller states.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DIV  = 2'b01,
        DONE = 2'b10
    } state_e;

    // All DIV/DIVU/REM/REMU encodings have funct3[2] set.
    function automatic logic is_divrem(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Pipeline-side bundle of the multiply/divide unit: ID/EX operands,
// forwarding inputs, flush, and the result/stall signals back.
interface ex_muldiv_unit_if #(parameter int XLEN = 32);

    logic            in_valid;
    logic [2:0]      funct3;
    logic [4:0]      rd_in;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] mem_fwd_data;
    logic [XLEN-1:0] wb_fwd_data;
    logic [1:0]      forward_a;
    logic [1:0]      forward_b;
    logic            flush;
    logic            stall;
    logic            out_valid;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output in_valid, funct3, rd_in, rs1_data, rs2_data,
               mem_fwd_data, wb_fwd_data, forward_a, forward_b, flush,
        input  stall, out_valid, result, rd_out
    );

    modport slave (
        input  in_valid, funct3, rd_in, rs1_data, rs2_data,
               mem_fwd_data, wb_fwd_data, forward_a, forward_b, flush,
        output stall, out_valid, result, rd_out
    );

endinterface

// File: rtl/ex_muldiv_unit_div_core.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// quotient/remainder show the post-step values, so they are final while done=1.
module div_core #(
    parameter int XLEN      = 32,
    parameter int DIV_STEPS = XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            kill,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            done
);

    localparam int CNT_W = $clog2(DIV_STEPS + 1);

    logic [XLEN-1:0]  rem_r;
    logic [XLEN-1:0]  quo_r;
    logic [XLEN-1:0]  dsr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;

    logic [XLEN:0]    partial_s;
    logic [XLEN:0]    diff_s;
    logic [XLEN-1:0]  rem_next_s;
    logic [XLEN-1:0]  quo_next_s;
    logic             qbit_s;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        partial_s = {rem_r, quo_r[XLEN-1]};
        diff_s    = partial_s - {1'b0, dsr_r};
        if (diff_s[XLEN] == 1'b0) begin
            rem_next_s = diff_s[XLEN-1:0];
            qbit_s     = 1'b1;
        end else begin
            rem_next_s = partial_s[XLEN-1:0];
            qbit_s     = 1'b0;
        end
        quo_next_s = {quo_r[XLEN-2:0], qbit_s};
    end

    // Divider state: load on start, step while busy, abort on kill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r  <= {XLEN{1'b0}};
            quo_r  <= {XLEN{1'b0}};
            dsr_r  <= {XLEN{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            busy_r <= 1'b0;
        end else if (kill) begin
            cnt_r  <= {CNT_W{1'b0}};
            busy_r <= 1'b0;
        end else if (start) begin
            rem_r  <= {XLEN{1'b0}};
            quo_r  <= dividend;
            dsr_r  <= divisor;
            cnt_r  <= CNT_W'(DIV_STEPS - 1);
            busy_r <= 1'b1;
        end else if (busy_r) begin
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
            if (cnt_r == {CNT_W{1'b0}}) begin
                busy_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
        end
    end

    assign quotient  = quo_next_s;
    assign remainder = rem_next_s;
    assign done      = busy_r && (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage RV32M unit: forwarding muxes, single-cycle multiplier, iterative
// divider with sign fix-up, and the registered result toward EX/MEM.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DIV_STEPS = XLEN
) (
    input  logic               clk,
    input  logic               rst_n,
    ex_muldiv_unit_if.slave    bus
);

    state_e            state_r;
    state_e            state_next_s;

    logic [XLEN-1:0]   op_a_s;
    logic [XLEN-1:0]   op_b_s;
    logic              issue_s;
    logic              issue_div_s;

    logic              mul_a_sx_s;
    logic              mul_b_sx_s;
    logic [2*XLEN-1:0] mul_a_s;
    logic [2*XLEN-1:0] mul_b_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   mul_res_s;

    logic              div_signed_s;
    logic [XLEN-1:0]   div_dividend_s;
    logic [XLEN-1:0]   div_divisor_s;
    logic [XLEN-1:0]   div_q_s;
    logic [XLEN-1:0]   div_r_s;
    logic              div_done_s;

    logic [XLEN-1:0]   a_r;
    logic [XLEN-1:0]   b_r;
    logic              signed_r;
    logic              rem_sel_r;
    logic [4:0]        rd_r;

    logic [XLEN-1:0]   q_fix_s;
    logic [XLEN-1:0]   r_fix_s;
    logic [XLEN-1:0]   div_res_s;

    logic              out_valid_r;
    logic [XLEN-1:0]   result_r;
    logic [4:0]        rd_out_r;

    // Operand selection from the forwarding codes; code 11 falls back to the register file.
    always_comb begin
        case (bus.forward_a)
            FWD_WB:  op_a_s = bus.wb_fwd_data;
            FWD_MEM: op_a_s = bus.mem_fwd_data;
            default: op_a_s = bus.rs1_data;
        endcase
        case (bus.forward_b)
            FWD_WB:  op_b_s = bus.wb_fwd_data;
            FWD_MEM: op_b_s = bus.mem_fwd_data;
            default: op_b_s = bus.rs2_data;
        endcase
    end

    // Issue qualification, multiplier, and divider operand magnitudes.
    always_comb begin
        issue_s     = bus.in_valid && !bus.flush && ((state_r == IDLE) || (state_r == DONE));
        issue_div_s = issue_s && is_divrem(bus.funct3);

        case (bus.funct3)
            F3_MUL, F3_MULH: begin
                mul_a_sx_s = 1'b1;
                mul_b_sx_s = 1'b1;
            end
            F3_MULHSU: begin
                mul_a_sx_s = 1'b1;
                mul_b_sx_s = 1'b0;
            end
            default: begin
                mul_a_sx_s = 1'b0;
                mul_b_sx_s = 1'b0;
            end
        endcase
        // Extending to 2*XLEN makes a plain product exact for every signedness mix.
        mul_a_s = {{XLEN{mul_a_sx_s & op_a_s[XLEN-1]}}, op_a_s};
        mul_b_s = {{XLEN{mul_b_sx_s & op_b_s[XLEN-1]}}, op_b_s};
        prod_s  = mul_a_s * mul_b_s;
        if (bus.funct3 == F3_MUL) begin
            mul_res_s = prod_s[XLEN-1:0];
        end else begin
            mul_res_s = prod_s[2*XLEN-1:XLEN];
        end

        div_signed_s = !bus.funct3[0];
        if (div_signed_s && op_a_s[XLEN-1]) begin
            div_dividend_s = -op_a_s;
        end else begin
            div_dividend_s = op_a_s;
        end
        if (div_signed_s && op_b_s[XLEN-1]) begin
            div_divisor_s = -op_b_s;
        end else begin
            div_divisor_s = op_b_s;
        end
    end

    div_core #(
        .XLEN      (XLEN),
        .DIV_STEPS (DIV_STEPS)
    ) u_div_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .kill      (bus.flush),
        .start     (issue_div_s),
        .dividend  (div_dividend_s),
        .divisor   (div_divisor_s),
        .quotient  (div_q_s),
        .remainder (div_r_s),
        .done      (div_done_s)
    );

    // Sign restoration and the RISC-V divide-by-zero / overflow results.
    always_comb begin
        if (b_r == {XLEN{1'b0}}) begin
            q_fix_s = {XLEN{1'b1}};
            r_fix_s = a_r;
        end else if (signed_r && (a_r == {1'b1, {(XLEN-1){1'b0}}}) && (b_r == {XLEN{1'b1}})) begin
            q_fix_s = a_r;
            r_fix_s = {XLEN{1'b0}};
        end else begin
            if (signed_r && (a_r[XLEN-1] ^ b_r[XLEN-1])) begin
                q_fix_s = -div_q_s;
            end else begin
                q_fix_s = div_q_s;
            end
            if (signed_r && a_r[XLEN-1]) begin
                r_fix_s = -div_r_s;
            end else begin
                r_fix_s = div_r_s;
            end
        end
        if (rem_sel_r) begin
            div_res_s = r_fix_s;
        end else begin
            div_res_s = q_fix_s;
        end
    end

    // Controller next state; flush overrides everything.
    always_comb begin
        state_next_s = state_r;
        if (bus.flush) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (issue_div_s) begin
                        state_next_s = DIV;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                DIV: begin
                    if (div_done_s) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = DIV;
                    end
                end
                DONE: begin
                    if (issue_div_s) begin
                        state_next_s = DIV;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Issue-time capture of the operands and op flags used by the fix-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r       <= {XLEN{1'b0}};
            b_r       <= {XLEN{1'b0}};
            signed_r  <= 1'b0;
            rem_sel_r <= 1'b0;
            rd_r      <= 5'd0;
        end else if (issue_s) begin
            a_r       <= op_a_s;
            b_r       <= op_b_s;
            signed_r  <= !bus.funct3[0];
            rem_sel_r <= bus.funct3[1];
            rd_r      <= bus.rd_in;
        end
    end

    // Result register: multiplies one cycle after issue, divides on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            result_r    <= {XLEN{1'b0}};
            rd_out_r    <= 5'd0;
        end else if (bus.flush) begin
            out_valid_r <= 1'b0;
        end else if (issue_s && !issue_div_s) begin
            out_valid_r <= 1'b1;
            result_r    <= mul_res_s;
            rd_out_r    <= bus.rd_in;
        end else if ((state_r == DIV) && div_done_s) begin
            out_valid_r <= 1'b1;
            result_r    <= div_res_s;
            rd_out_r    <= rd_r;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.stall     = (state_r == DIV) || issue_div_s;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.rd_out    = rd_out_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: an arithmetic reference model and a
// timing scoreboard checked every cycle, plus literal pins on the model.
module tb_ex_muldiv_unit;

    localparam int XLEN      = 32;
    localparam int DIV_STEPS = 32;

    typedef struct {
        int          cyc;
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lit;
    } dvec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;
    int   div_start = 0;
    int   div_end = -1;
    exp_t exp_q[$];

    ex_muldiv_unit_if #(.XLEN(XLEN)) bus ();

    ex_muldiv_unit #(.XLEN(XLEN), .DIV_STEPS(DIV_STEPS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] rf,
                                         input logic [31:0] wb, input logic [31:0] mem);
        if (s == 2'b01) return wb;
        if (s == 2'b10) return mem;
        return rf;
    endfunction

    // RV32M semantics in plain 64-bit arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa, sbv, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        p   = 64'd0;
        r   = 32'd0;
        case (f)
            3'b000: begin p = sa * sbv; r = p[31:0];  end
            3'b001: begin p = sa * sbv; r = p[63:32]; end
            3'b010: begin p = sa * ub;  r = p[63:32]; end
            3'b011: begin p = ua * ub;  r = p[63:32]; end
            3'b100: begin if (b == 32'd0) r = 32'hFFFFFFFF; else begin p = sa / sbv; r = p[31:0]; end end
            3'b101: begin if (b == 32'd0) r = 32'hFFFFFFFF; else begin p = ua / ub;  r = p[31:0]; end end
            3'b110: begin if (b == 32'd0) r = a;            else begin p = sa % sbv; r = p[31:0]; end end
            default: begin if (b == 32'd0) r = a;           else begin p = ua % ub;  r = p[31:0]; end end
        endcase
        return r;
    endfunction

    task automatic scramble();
        bus.in_valid     = 1'b0;
        bus.funct3       = 3'($urandom);
        bus.rd_in        = 5'($urandom);
        bus.rs1_data     = $urandom;
        bus.rs2_data     = $urandom;
        bus.mem_fwd_data = $urandom;
        bus.wb_fwd_data  = $urandom;
        bus.forward_a    = 2'($urandom);
        bus.forward_b    = 2'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one op for one cycle and record when and what it must produce.
    task automatic issue(input logic [2:0] f, input logic [1:0] fa, input logic [1:0] fb,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] mem, input logic [31:0] wb,
                         input logic [4:0] rd, input logic [31:0] lit);
        logic [31:0] a, b, r;
        exp_t e;
        bus.in_valid = 1'b1;  bus.funct3 = f;  bus.rd_in = rd;
        bus.rs1_data = rs1;   bus.rs2_data = rs2;
        bus.mem_fwd_data = mem;  bus.wb_fwd_data = wb;
        bus.forward_a = fa;   bus.forward_b = fb;
        a = pick(fa, rs1, wb, mem);
        b = pick(fb, rs2, wb, mem);
        r = ref_op(f, a, b);
        tests++;
        if (r !== lit) begin
            fails++;
            $display("FAIL model_pin f3=%0d: model %h required %h", f, r, lit);
        end
        e.cyc = cyc + (f[2] ? DIV_STEPS + 1 : 1);
        e.res = r;
        e.rd  = rd;
        exp_q.push_back(e);
        if (f[2]) begin
            div_start = cyc;
            div_end   = cyc + DIV_STEPS;
        end
        @(posedge clk);
        #1;
        scramble();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Per-cycle comparison of out_valid/result/rd_out/stall against the scoreboard.
    always @(negedge clk) begin
        if (chk_en) begin
            bit exp_v, exp_stall;
            exp_v     = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            exp_stall = (cyc >= div_start) && (cyc <= div_end);
            check($sformatf("out_valid@%0d", cyc), {31'd0, bus.out_valid}, {31'd0, exp_v});
            check($sformatf("stall@%0d", cyc), {31'd0, bus.stall}, {31'd0, exp_stall});
            if (exp_v) begin
                check($sformatf("result@%0d", cyc), bus.result, exp_q[0].res);
                check($sformatf("rd_out@%0d", cyc), {27'd0, bus.rd_out}, {27'd0, exp_q[0].rd});
                void'(exp_q.pop_front());
            end else if ((exp_q.size() > 0) && (exp_q[0].cyc < cyc)) begin
                void'(exp_q.pop_front());
            end
        end
    end

    dvec_t dv[$];

    initial begin
        rst_n = 1'b0;
        scramble();
        bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset_stall", {31'd0, bus.stall}, 32'd0);
        check("reset_result", bus.result, 32'd0);
        check("reset_rd_out", {27'd0, bus.rd_out}, 32'd0);
        rst_n = 1'b1;
        idle(1);
        chk_en = 1'b1;

        // Forwarding selects and multiply variants, back to back.
        issue(3'b000, 2'b10, 2'b00, 32'd3, 32'd5, 32'd7, 32'd99, 5'd1, 32'd35);
        issue(3'b000, 2'b01, 2'b00, 32'd3, 32'd5, 32'd7, 32'd4,  5'd2, 32'd20);
        issue(3'b000, 2'b11, 2'b00, 32'd6, 32'd5, 32'd7, 32'd4,  5'd0, 32'd30);
        issue(3'b001, 2'b00, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd3, 32'h00000000);
        issue(3'b010, 2'b00, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd4, 32'hFFFFFFFF);
        issue(3'b011, 2'b00, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd5, 32'hFFFFFFFE);
        issue(3'b000, 2'b00, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd6, 32'h00000001);
        issue(3'b001, 2'b00, 2'b00, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 5'd7, 32'h40000000);
        idle(2);

        // Divides chained so each new op issues in the previous one's DONE cycle.
        dv.push_back('{3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD});
        dv.push_back('{3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF});
        dv.push_back('{3'b101, 32'd5, 32'd0, 32'hFFFFFFFF});
        dv.push_back('{3'b110, 32'd5, 32'd0, 32'd5});
        dv.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000});
        dv.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0});
        dv.push_back('{3'b101, 32'd100, 32'd7, 32'd14});
        dv.push_back('{3'b111, 32'd100, 32'd7, 32'd2});
        dv.push_back('{3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD});
        dv.push_back('{3'b110, 32'd7, 32'hFFFFFFFE, 32'd1});
        dv.push_back('{3'b101, 32'hFFFFFFFF, 32'd10, 32'h19999999});
        dv.push_back('{3'b111, 32'hFFFFFFFF, 32'd10, 32'd5});
        dv.push_back('{3'b100, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF});
        dv.push_back('{3'b110, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9});
        foreach (dv[i]) begin
            issue(dv[i].f, 2'b00, 2'b10, dv[i].a, 32'd0, dv[i].b, 32'd0, 5'(i + 8), dv[i].lit);
            idle(DIV_STEPS);
        end
        issue(3'b000, 2'b00, 2'b00, 32'd2, 32'd3, 32'd0, 32'd0, 5'd30, 32'd6);
        idle(2);

        // Flush at T+10 of a divide, with a MUL offered in the flush cycle.
        issue(3'b101, 2'b00, 2'b00, 32'd100, 32'd7, 32'd0, 32'd0, 5'd11, 32'd14);
        idle(9);
        bus.flush = 1'b1;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc > cyc) exp_q.delete(i);
        end
        div_end = cyc;
        bus.in_valid = 1'b1;  bus.funct3 = 3'b000;
        bus.forward_a = 2'b00; bus.forward_b = 2'b00;
        idle(1);
        bus.flush = 1'b0;
        scramble();
        idle(30);

        // A divide offered together with flush from IDLE is not issued.
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;  bus.funct3 = 3'b100;
        idle(1);
        bus.flush = 1'b0;
        scramble();
        idle(3);
        issue(3'b000, 2'b00, 2'b01, 32'd4, 32'd0, 32'd0, 32'd5, 5'd9, 32'd20);
        idle(2);

        // Asynchronous reset in the middle of a divide.
        issue(3'b100, 2'b00, 2'b00, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 5'd12, 32'hFFFFFFFD);
        idle(4);
        #2;
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_mid_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_mid_result", bus.result, 32'd0);
        check("rst_mid_rd_out", {27'd0, bus.rd_out}, 32'd0);
        exp_q.delete();
        div_end = -1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        issue(3'b000, 2'b00, 2'b00, 32'd2, 32'd3, 32'd0, 32'd0, 5'd13, 32'd6);
        idle(3);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
